// File: rtl/finish_banner_ctrl.sv
// finish_banner_ctrl: sequences the FINISH banner (drop, blink, hold) and
// composites the text renderer's pixels over the background with one
// registered stage.
module finish_banner_ctrl #(
   parameter int H_ACTIVE      = 640,
   parameter int TEXT_W        = 52,
   parameter int START_Y       = 0,
   parameter int TARGET_Y      = 236,
   parameter int DROP_STEP     = 4,
   parameter int BLINK_FRAMES  = 16,
   parameter int BLINK_TOGGLES = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        finish_trig,
   input  logic        clear,
   input  logic        frame_start,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        pix_valid,
   input  logic [23:0] bg_color,
   input  logic [23:0] txt_color,
   input  logic        txt_en,
   output logic [9:0]  text_x,
   output logic [9:0]  text_y,
   output logic [23:0] out_color,
   output logic        out_valid,
   output logic        busy,
   output logic        done
);

   localparam int FC_W = (BLINK_FRAMES  > 1) ? $clog2(BLINK_FRAMES)  : 1;
   localparam int TC_W = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;

   localparam logic [FC_W-1:0] FRAME_LAST  = FC_W'(BLINK_FRAMES - 1);
   localparam logic [TC_W-1:0] TOGGLE_LAST = TC_W'(BLINK_TOGGLES - 1);
   localparam logic [9:0]      START_Y10   = 10'(START_Y);
   localparam logic [9:0]      TARGET_Y10  = 10'(TARGET_Y);
   localparam logic [10:0]     STEP11      = 11'(DROP_STEP);
   localparam logic [10:0]     TARGET11    = 11'(TARGET_Y);
   localparam logic [9:0]      TEXT_X10    = 10'((H_ACTIVE - TEXT_W) / 2);

   typedef enum logic [1:0] {IDLE, DROP, BLINK, HOLD} state_t;

   state_t          state;
   logic            show;
   logic [FC_W-1:0] frame_cnt;
   logic [TC_W-1:0] toggle_cnt;
   logic [9:0]      drop_y;

   // The sum is formed one bit wider than text_y so a large step can never
   // wrap past zero before it is clamped to the landing row.
   function automatic logic [9:0] clamp_step(input logic [9:0] cur_y);
      logic [10:0] sum;
      sum = {1'b0, cur_y} + STEP11;
      return (sum >= TARGET11) ? TARGET_Y10 : sum[9:0];
   endfunction

   // x/y only feed the external renderer; the banner origin is fixed in x.
   logic unused_xy;
   assign unused_xy = ^{x, y};
   assign text_x    = TEXT_X10;
   assign drop_y    = clamp_step(text_y);

   // Animation sequencer: text_y and show move only on frame_start or on a
   // state entry, so the banner never tears mid-frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         text_y     <= START_Y10;
         show       <= 1'b0;
         frame_cnt  <= '0;
         toggle_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else if (clear) begin
         // clear overrides every other event, including a same-cycle trigger
         state      <= IDLE;
         text_y     <= START_Y10;
         show       <= 1'b0;
         frame_cnt  <= '0;
         toggle_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               show <= 1'b0;
               // a coincident frame_start is deliberately not a drop step
               if (finish_trig) begin
                  state  <= DROP;
                  text_y <= START_Y10;
                  show   <= 1'b1;
                  busy   <= 1'b1;
                  done   <= 1'b0;
               end
            end
            DROP: begin
               if (frame_start) begin
                  text_y <= drop_y;
                  if (drop_y == TARGET_Y10) begin
                     state      <= BLINK;
                     frame_cnt  <= '0;
                     toggle_cnt <= '0;
                  end
               end
            end
            BLINK: begin
               if (frame_start) begin
                  if (frame_cnt == FRAME_LAST) begin
                     frame_cnt <= '0;
                     if (toggle_cnt == TOGGLE_LAST) begin
                        // last half-period ends with the banner left visible
                        state      <= HOLD;
                        show       <= 1'b1;
                        toggle_cnt <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                     end else begin
                        show       <= ~show;
                        toggle_cnt <= toggle_cnt + 1'b1;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               show   <= 1'b1;
               text_y <= TARGET_Y10;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Composite stage: text over background when visible, black outside DE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_color <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= pix_valid;
         if (!pix_valid)
            out_color <= '0;
         else if (show && txt_en)
            out_color <= txt_color;
         else
            out_color <= bg_color;
      end
   end

endmodule

// File: tb/tb_finish_banner_ctrl.sv
// tb_finish_banner_ctrl: directed bench for finish_banner_ctrl with the default
// step of 4 and a second instance using a step of 5 to exercise the clamp.
module tb_finish_banner_ctrl;

   localparam logic [23:0] RED  = 24'hFF0000;
   localparam logic [23:0] BLUE = 24'h0000FF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        finish_trig = 1'b0;
   logic        clear = 1'b0;
   logic        frame_start = 1'b0;
   logic [9:0]  x = 10'd300;
   logic [9:0]  y = 10'd240;
   logic        pix_valid = 1'b0;
   logic [23:0] bg_color = BLUE;
   logic [23:0] txt_color = RED;
   logic        txt_en = 1'b1;

   logic [9:0]  text_x4, text_y4, text_x5, text_y5;
   logic [23:0] out_color4, out_color5;
   logic        out_valid4, out_valid5, busy4, busy5, done4, done5;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   finish_banner_ctrl u4 (
      .clk(clk), .rst_n(rst_n), .finish_trig(finish_trig), .clear(clear),
      .frame_start(frame_start), .x(x), .y(y), .pix_valid(pix_valid),
      .bg_color(bg_color), .txt_color(txt_color), .txt_en(txt_en),
      .text_x(text_x4), .text_y(text_y4), .out_color(out_color4),
      .out_valid(out_valid4), .busy(busy4), .done(done4)
   );

   finish_banner_ctrl #(.DROP_STEP(5)) u5 (
      .clk(clk), .rst_n(rst_n), .finish_trig(finish_trig), .clear(clear),
      .frame_start(frame_start), .x(x), .y(y), .pix_valid(pix_valid),
      .bg_color(bg_color), .txt_color(txt_color), .txt_en(txt_en),
      .text_x(text_x5), .text_y(text_y5), .out_color(out_color5),
      .out_valid(out_valid5), .busy(busy5), .done(done5)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one frame_start pulse, then an idle cycle so out_color shows the new visibility
   task automatic pulse_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
   endtask

   // Expected animation after f frame pulses; t = frame on which the banner lands.
   function automatic logic [9:0] exp_y(input int step, input int t, input int f);
      return (f < t) ? 10'(step * f) : 10'd236;
   endfunction
   function automatic logic exp_show(input int t, input int f);
      if (f < t || f - t >= 96) return 1'b1;
      return (((f - t) / 16) % 2) == 0;
   endfunction

   initial begin
      // reset
      #2 rst_n = 1'b0;
      pix_valid = 1'b1;
      tick(); tick();
      chk("rst text_y", 32'(text_y4), 32'd0);
      chk("rst text_x", 32'(text_x4), 32'd294);
      chk("rst out_color", 32'(out_color4), 32'd0);
      chk("rst out_valid", 32'(out_valid4), 32'd0);
      chk("rst busy", 32'(busy4), 32'd0);
      chk("rst done", 32'(done4), 32'd0);
      rst_n = 1'b1;

      // idle: banner hidden, background passes
      tick();
      chk("idle out_color", 32'(out_color4), 32'(BLUE));
      chk("idle out_valid", 32'(out_valid4), 32'd1);

      // trigger coincident with frame_start: enter DROP without stepping
      finish_trig = 1'b1;
      frame_start = 1'b1;
      tick();
      finish_trig = 1'b0;
      frame_start = 1'b0;
      chk("trig busy", 32'(busy4), 32'd1);
      chk("trig text_y", 32'(text_y4), 32'd0);
      chk("trig text_y5", 32'(text_y5), 32'd0);
      tick();
      chk("show txt", 32'(out_color4), 32'(RED));
      txt_en = 1'b0;
      tick();
      chk("txt_en0 bg", 32'(out_color4), 32'(BLUE));
      txt_en = 1'b1;
      pix_valid = 1'b0;
      tick();
      chk("blank color", 32'(out_color4), 32'd0);
      chk("blank valid", 32'(out_valid4), 32'd0);
      pix_valid = 1'b1;
      tick();

      // drop, blink and hold for both step sizes
      for (int f = 1; f <= 158; f++) begin
         pulse_frame();
         chk($sformatf("u4 text_y f%0d", f), 32'(text_y4), 32'(exp_y(4, 59, f)));
         chk($sformatf("u4 busy f%0d", f), 32'(busy4), 32'(f < 59 + 96));
         chk($sformatf("u4 done f%0d", f), 32'(done4), 32'(f >= 59 + 96));
         chk($sformatf("u4 color f%0d", f), 32'(out_color4),
             32'(exp_show(59, f) ? RED : BLUE));
         chk($sformatf("u5 text_y f%0d", f), 32'(text_y5), 32'(exp_y(5, 48, f)));
         chk($sformatf("u5 busy f%0d", f), 32'(busy5), 32'(f < 48 + 96));
         chk($sformatf("u5 done f%0d", f), 32'(done5), 32'(f >= 48 + 96));
         chk($sformatf("u5 color f%0d", f), 32'(out_color5),
             32'(exp_show(48, f) ? RED : BLUE));
         if (f == 70) begin
            // trigger during BLINK must not restart anything
            finish_trig = 1'b1;
            tick();
            finish_trig = 1'b0;
            chk("blink trig text_y", 32'(text_y4), 32'd236);
            chk("blink trig busy", 32'(busy4), 32'd1);
         end
      end

      // clear from HOLD
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr hold done", 32'(done4), 32'd0);
      chk("clr hold text_y", 32'(text_y4), 32'd0);
      tick();
      chk("clr hold color", 32'(out_color4), 32'(BLUE));

      // clear with trigger: clear wins
      clear = 1'b1;
      finish_trig = 1'b1;
      tick();
      clear = 1'b0;
      finish_trig = 1'b0;
      chk("clr+trig busy", 32'(busy4), 32'd0);

      // clear during DROP
      finish_trig = 1'b1;
      tick();
      finish_trig = 1'b0;
      pulse_frame(); pulse_frame(); pulse_frame();
      chk("redrop text_y", 32'(text_y4), 32'd12);
      chk("redrop color", 32'(out_color4), 32'(RED));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr drop busy", 32'(busy4), 32'd0);
      chk("clr drop text_y", 32'(text_y4), 32'd0);
      tick();
      chk("clr drop color", 32'(out_color4), 32'(BLUE));

      // asynchronous reset mid-animation
      finish_trig = 1'b1;
      tick();
      finish_trig = 1'b0;
      pulse_frame(); pulse_frame();
      chk("pre-areset text_y", 32'(text_y4), 32'd8);
      #2 rst_n = 1'b0;
      #1;
      chk("areset text_y", 32'(text_y4), 32'd0);
      chk("areset busy", 32'(busy4), 32'd0);
      chk("areset color", 32'(out_color4), 32'd0);
      chk("areset valid", 32'(out_valid4), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
